// File: rtl/pio_pkg.sv
// Shared definitions for the edge-capture PIO servicer: target register map,
// clear-all write value and the servicer state encoding.
package pio_pkg;

    localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0]  PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0]  PIO_ADDR_EDGE = 2'd3;
    localparam logic [31:0] PIO_CLR_ALL   = 32'h1;

    typedef enum logic [2:0] {
        ST_START,
        ST_INIT_MASK,
        ST_INIT_CLR,
        ST_IDLE,
        ST_RD_EC,
        ST_CLR_EC,
        ST_HOLDOFF,
        ST_FLUSH
    } svc_state_e;

endpackage

// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator that arms a button PIO, services its edge-capture irq and
// counts debounced presses, discarding bounce edges during a hold-off window.
module pio_irq_servicer
    import pio_pkg::*;
#(
    parameter int COUNT_WIDTH    = 8,
    parameter int HOLDOFF_CYCLES = 50000,
    parameter int READ_LATENCY   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   m_irq,
    input  logic [31:0]            m_readdata,
    output logic [1:0]             m_address,
    output logic                   m_chipselect,
    output logic                   m_write_n,
    output logic [31:0]            m_writedata,
    output logic [COUNT_WIDTH-1:0] event_count,
    output logic                   event_pulse,
    output logic                   busy
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    svc_state_e        state, state_next;
    logic [2:0]        lat_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              lat_done;
    logic              hold_done;
    logic              unused_rd;

    assign lat_done  = (lat_cnt == LAT_LAST);
    assign hold_done = (hold_cnt == '0);
    assign unused_rd = ^m_readdata[31:1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_START;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_START:     state_next = ST_INIT_MASK;
            ST_INIT_MASK: state_next = ST_INIT_CLR;
            ST_INIT_CLR:  state_next = ST_IDLE;
            ST_IDLE:      if (enable && m_irq) state_next = ST_RD_EC;
            ST_RD_EC:     if (lat_done) state_next = m_readdata[0] ? ST_CLR_EC : ST_IDLE;
            ST_CLR_EC:    state_next = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
            ST_HOLDOFF:   if (hold_done) state_next = ST_FLUSH;
            ST_FLUSH:     state_next = ST_IDLE;
            default:      state_next = ST_START;
        endcase
    end

    // Bus outputs depend on the state register alone: no input-to-output path.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = PIO_ADDR_DATA;
        m_writedata  = '0;
        case (state)
            ST_INIT_MASK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = PIO_ADDR_MASK;
                m_writedata  = PIO_CLR_ALL;
            end
            ST_INIT_CLR, ST_CLR_EC, ST_FLUSH: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = PIO_ADDR_EDGE;
                m_writedata  = PIO_CLR_ALL;
            end
            ST_RD_EC: begin
                m_chipselect = 1'b1;
                m_address    = PIO_ADDR_EDGE;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt     <= '0;
            hold_cnt    <= '0;
            event_count <= '0;
            event_pulse <= 1'b0;
        end else begin
            lat_cnt     <= (state == ST_RD_EC && !lat_done) ? lat_cnt + 3'd1 : 3'd0;
            event_pulse <= (state == ST_CLR_EC);
            if (state == ST_CLR_EC) begin
                event_count <= event_count + COUNT_WIDTH'(1);
                hold_cnt    <= HOLD_LOAD;
            end else if (state == ST_HOLDOFF && !hold_done) begin
                hold_cnt    <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Self-checking bench: behavioural edge-capture PIO target, vector table of
// service scenarios, hand-written reset/enable sequences and random presses.
module tb_pio_irq_servicer;
    import pio_pkg::*;

    localparam int CW = 2;
    localparam int HC = 10;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          m_irq;
    logic [31:0]   m_readdata;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [CW-1:0] event_count;
    logic          event_pulse;
    logic          busy;

    always #5 clk = ~clk;

    pio_irq_servicer #(
        .COUNT_WIDTH(CW), .HOLDOFF_CYCLES(HC), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .m_irq(m_irq),
        .m_readdata(m_readdata), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .event_count(event_count),
        .event_pulse(event_pulse), .busy(busy)
    );

    // ---------------- behavioural button PIO ----------------
    logic        in_port = 1'b0;
    logic        in_d = 1'b0;
    logic        force_irq = 1'b0;
    logic [31:0] ec = '0;
    logic [31:0] mask = '0;
    logic [31:0] rd_pipe [RL] = '{default: '0};
    logic        pio_irq;

    function automatic logic [31:0] reg_val(input logic [1:0] a);
        case (a)
            2'd0:    return {31'b0, in_port};
            2'd2:    return mask;
            2'd3:    return ec;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        in_d <= in_port;
        if (m_chipselect && !m_write_n && m_address == 2'd2) mask <= m_writedata;
        if (m_chipselect && !m_write_n && m_address == 2'd3)
            ec <= (ec & ~m_writedata) | {31'b0, in_port & ~in_d};
        else
            ec <= ec | {31'b0, in_port & ~in_d};
        rd_pipe[0] <= (m_chipselect && m_write_n) ? reg_val(m_address) : '0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign pio_irq    = |(ec & mask);
    assign m_irq      = pio_irq | force_irq;
    assign m_readdata = rd_pipe[RL-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    int cyc = 0, wr_cnt = 0, rd_cycles = 0, pulse_cnt = 0;
    int wr_cyc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (reset_n && m_chipselect) begin
            if (!m_write_n) begin
                wr_cnt++;
                if (m_address == 2'd3) wr_cyc_q.push_back(cyc);
                check("wr_data", m_writedata, 32'h1);
            end else begin
                rd_cycles++;
                check("rd_addr", {30'b0, m_address}, 32'd3);
            end
        end
        if (event_pulse) pulse_cnt++;
    end

    // Reference model: each real press counts once modulo 2^CW.
    int exp_count = 0;

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_idle"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic init_seq(input string name);
        reset_n = 1'b1;
        #1;
        check({name, "_start_cs"}, {31'b0, m_chipselect}, 0);
        check({name, "_start_busy"}, {31'b0, busy}, 1);
        @(negedge clk);
        check({name, "_mask_wr"}, {m_chipselect, m_write_n, m_address}, {1'b1, 1'b0, 2'd2});
        check({name, "_mask_data"}, m_writedata, 1);
        @(negedge clk);
        check({name, "_clr_wr"}, {m_chipselect, m_write_n, m_address}, {1'b1, 1'b0, 2'd3});
        check({name, "_clr_data"}, m_writedata, 1);
        @(negedge clk);
        check({name, "_idle_busy"}, {31'b0, busy}, 0);
        check({name, "_idle_cs"}, {31'b0, m_chipselect}, 0);
        check({name, "_irq_mask"}, mask, 1);
    endtask

    task automatic press(input int nb, input int hold);
        in_port = 1'b1;
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            in_port = 1'b0;
            @(negedge clk);
            in_port = 1'b1;
            @(negedge clk);
        end
        repeat (hold) @(negedge clk);
        in_port = 1'b0;
    endtask

    task automatic run_case(input string name, input bit spur, input int nb, input int hold,
                            input bit drop_en, input int exp_pulses, input int exp_writes);
        int p0, w0, r0;
        p0 = pulse_cnt; w0 = wr_cnt; r0 = rd_cycles;
        wr_cyc_q.delete();
        if (spur) begin
            force_irq = 1'b1;
            @(negedge clk);
            force_irq = 1'b0;
            @(negedge clk);
        end else begin
            press(nb, hold);
        end
        exp_count = (exp_count + exp_pulses) % (1 << CW);
        if (drop_en) enable = 1'b0;
        wait_idle(name);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        check({name, "_count"}, {30'b0, event_count}, exp_count);
        check({name, "_pulses"}, pulse_cnt - p0, exp_pulses);
        check({name, "_writes"}, wr_cnt - w0, exp_writes);
        check({name, "_rd_cycles"}, rd_cycles - r0, RL + 1);
        if (exp_writes == 2)
            check({name, "_flush_gap"},
                  (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : 0, HC + 1);
        check({name, "_irq_low"}, {31'b0, pio_irq}, 0);
    endtask

    typedef struct {
        string name;
        bit    spur;
        int    bounces;
        int    hold;
        bit    drop_en;
        int    exp_pulses;
        int    exp_writes;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int p0, w0, r0;
        int seq[5];

        vecs[0] = '{"single",   1'b0, 0, 4, 1'b0, 1, 2};
        vecs[1] = '{"bounce5",  1'b0, 5, 3, 1'b0, 1, 2};
        vecs[2] = '{"spurious", 1'b1, 0, 0, 1'b0, 0, 0};
        vecs[3] = '{"en_drop",  1'b0, 2, 3, 1'b1, 1, 2};

        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", {30'b0, event_count}, 0);
        check("rst_pulse", {31'b0, event_pulse}, 0);
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_bus", {m_chipselect, m_write_n, m_address}, {1'b0, 1'b1, 2'd0});
        check("rst_wdata", m_writedata, 0);
        init_seq("init");

        for (int i = 0; i < 4; i++)
            run_case(vecs[i].name, vecs[i].spur, vecs[i].bounces, vecs[i].hold,
                     vecs[i].drop_en, vecs[i].exp_pulses, vecs[i].exp_writes);

        // Reset during hold-off: count clears and init reruns.
        in_port = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (event_pulse) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("hr_pulse_seen", {31'b0, seen}, 1);
        end
        repeat (3) @(negedge clk);
        in_port = 1'b0;
        reset_n = 1'b0;
        #1;
        check("hr_count", {30'b0, event_count}, 0);
        check("hr_busy", {31'b0, busy}, 1);
        check("hr_cs", {31'b0, m_chipselect}, 0);
        exp_count = 0;
        repeat (2) @(negedge clk);
        init_seq("reinit");

        // Wrap sequence.
        seq = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            p0 = pulse_cnt;
            press(0, 3);
            wait_idle("wrap");
            repeat (3) @(negedge clk);
            exp_count = (exp_count + 1) % (1 << CW);
            check("wrap_seq", {30'b0, event_count}, seq[i]);
            check("wrap_pulse", pulse_cnt - p0, 1);
        end

        // enable low with pending press: no traffic, irq held.
        enable = 1'b0;
        p0 = pulse_cnt; w0 = wr_cnt; r0 = rd_cycles;
        press(0, 3);
        repeat (25) @(negedge clk);
        check("dis_writes", wr_cnt - w0, 0);
        check("dis_reads", rd_cycles - r0, 0);
        check("dis_irq", {31'b0, pio_irq}, 1);
        check("dis_busy", {31'b0, busy}, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        wait_idle("en");
        repeat (3) @(negedge clk);
        exp_count = (exp_count + 1) % (1 << CW);
        check("en_count", {30'b0, event_count}, exp_count);
        check("en_pulse", pulse_cnt - p0, 1);
        check("en_irq", {31'b0, pio_irq}, 0);

        // Random presses against the counting model.
        for (int i = 0; i < 8; i++) begin
            run_case("rand", 1'b0, $urandom_range(0, 4), $urandom_range(3, 8),
                     1'($urandom_range(0, 1)), 1, 2);
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
